ir: RTL and testbench

- Instruction register of the 16-bit SAP CPU.
- Captures a 16-bit instruction word from the shared system bus on a control-unit load strobe and holds it until the next load.
- Presents the full word, the opcode field (to the controller/sequencer) and the operand field (to the bus/address path).
- Sits between the system bus and the control unit.

---
 rtl/sap_pkg.sv | 23 ++
 rtl/ir_field_split.sv | 26 ++
 rtl/ir.sv | 71 +++++++
 tb/tb_ir.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/sap_pkg.sv
// sap_pkg: shared constants and types for the 16-bit SAP CPU datapath.
//   DATA_W     - bus / instruction word width
//   OPCODE_W   - opcode field width (MSBs of the instruction word)
//   OPERAND_W  - operand field width (LSBs of the instruction word)
//   opcode_e   - instruction opcode encoding seen by the controller
package sap_pkg;

    localparam int DATA_W    = 16;
    localparam int OPCODE_W  = 4;
    localparam int OPERAND_W = DATA_W - OPCODE_W;

    typedef enum logic [OPCODE_W-1:0] {
        OP_LDA = 4'h0,
        OP_ADD = 4'h1,
        OP_SUB = 4'h2,
        OP_STA = 4'h3,
        OP_LDI = 4'h4,
        OP_JMP = 4'h5,
        OP_OUT = 4'hE,
        OP_HLT = 4'hF
    } opcode_e;

endpackage

// File: rtl/ir_field_split.sv
// ir_field_split: combinational decode of the held instruction word.
//   ir_word     in  - registered instruction word
//   ir_oe       in  - operand output enable
//   opcode      out - top OPCODE_W bits of ir_word
//   operand     out - remaining low bits of ir_word
//   operand_bus out - operand zero-extended when ir_oe=1, else zero
module ir_field_split
    import sap_pkg::*;
#(
    parameter int DATA_W   = sap_pkg::DATA_W,
    parameter int OPCODE_W = sap_pkg::OPCODE_W
) (
    input  logic [DATA_W-1:0]          ir_word,
    input  logic                       ir_oe,
    output logic [OPCODE_W-1:0]        opcode,
    output logic [DATA_W-OPCODE_W-1:0] operand,
    output logic [DATA_W-1:0]          operand_bus
);

    assign opcode  = ir_word[DATA_W-1 -: OPCODE_W];
    assign operand = ir_word[DATA_W-OPCODE_W-1:0];

    // Gated with zeros rather than tristated; bus muxing lives outside.
    assign operand_bus = ir_oe ? {{OPCODE_W{1'b0}}, operand} : '0;

endmodule

// File: rtl/ir.sv
// ir: instruction register of the 16-bit SAP CPU.
// Captures bus on ir_write, holds it, and exposes the word plus its
// opcode/operand fields. Synchronous active-low reset (rst=0) wins over load.
//   clk         in  - system clock, rising edge
//   rst         in  - synchronous active-low reset
//   ir_write    in  - load strobe
//   ir_oe       in  - operand_bus enable
//   bus         in  - system bus data
//   ir_out      out - registered instruction word
//   opcode      out - ir_out opcode field
//   operand     out - ir_out operand field
//   operand_bus out - zero-extended operand when ir_oe, else 0
//   ir_valid    out - an instruction has been loaded since reset
// Optional macro IR_ILLEGAL_DET_EN adds:
//   legal_mask  in  - one bit per opcode, 1 = legal
//   ir_illegal  out - registered: loaded opcode was not legal
module ir
    import sap_pkg::*;
#(
    parameter int                 DATA_W    = sap_pkg::DATA_W,
    parameter int                 OPCODE_W  = sap_pkg::OPCODE_W,
    parameter logic [DATA_W-1:0]  RESET_VAL = '0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       ir_write,
    input  logic                       ir_oe,
    input  logic [DATA_W-1:0]          bus,
`ifdef IR_ILLEGAL_DET_EN
    input  logic [2**OPCODE_W-1:0]     legal_mask,
    output logic                       ir_illegal,
`endif
    output logic [DATA_W-1:0]          ir_out,
    output logic [OPCODE_W-1:0]        opcode,
    output logic [DATA_W-OPCODE_W-1:0] operand,
    output logic [DATA_W-1:0]          operand_bus,
    output logic                       ir_valid
);

    always_ff @(posedge clk) begin
        if (!rst) begin
            ir_out   <= RESET_VAL;
            ir_valid <= 1'b0;
        end else if (ir_write) begin
            ir_out   <= bus;
            ir_valid <= 1'b1;
        end
    end

`ifdef IR_ILLEGAL_DET_EN
    // Judged on the incoming bus opcode so the flag lines up with ir_out.
    always_ff @(posedge clk) begin
        if (!rst)
            ir_illegal <= 1'b0;
        else if (ir_write)
            ir_illegal <= ~legal_mask[bus[DATA_W-1 -: OPCODE_W]];
    end
`endif

    ir_field_split #(
        .DATA_W   (DATA_W),
        .OPCODE_W (OPCODE_W)
    ) u_split (
        .ir_word     (ir_out),
        .ir_oe       (ir_oe),
        .opcode      (opcode),
        .operand     (operand),
        .operand_bus (operand_bus)
    );

endmodule

// File: tb/tb_ir.sv
// tb_ir: directed self-checking bench for the SAP instruction register.
module tb_ir;

    logic        clk = 1'b0;
    logic        rst;
    logic        ir_write;
    logic        ir_oe;
    logic [15:0] bus;
    logic [15:0] ir_out;
    logic [3:0]  opcode;
    logic [11:0] operand;
    logic [15:0] operand_bus;
    logic        ir_valid;
`ifdef IR_ILLEGAL_DET_EN
    logic [15:0] legal_mask;
    logic        ir_illegal;
`endif

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    ir dut (
        .clk         (clk),
        .rst         (rst),
        .ir_write    (ir_write),
        .ir_oe       (ir_oe),
        .bus         (bus),
`ifdef IR_ILLEGAL_DET_EN
        .legal_mask  (legal_mask),
        .ir_illegal  (ir_illegal),
`endif
        .ir_out      (ir_out),
        .opcode      (opcode),
        .operand     (operand),
        .operand_bus (operand_bus),
        .ir_valid    (ir_valid)
    );

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle 1 time unit past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; ir_write = 1'b0; ir_oe = 1'b0; bus = '0;
`ifdef IR_ILLEGAL_DET_EN
        legal_mask = 16'h00FF;
`endif
        #2;

        // Reset with a competing load
        rst = 1'b0; ir_write = 1'b1; bus = 16'hFFFF;
        step();
        check("rst_ir_out",  ir_out, 16'h0000);
        check("rst_valid",   {15'd0, ir_valid}, 16'd0);
        check("rst_opcode",  {12'd0, opcode}, 16'd0);
        check("rst_operand", {4'd0, operand}, 16'd0);
        check("rst_opbus",   operand_bus, 16'd0);

        // Single load
        rst = 1'b1; bus = 16'd74; ir_write = 1'b1;
        step();
        check("ld_ir_out",  ir_out, 16'h004A);
        check("ld_opcode",  {12'd0, opcode}, 16'h0000);
        check("ld_operand", {4'd0, operand}, 16'h004A);
        check("ld_valid",   {15'd0, ir_valid}, 16'd1);
        ir_oe = 1'b1; #1;
        check("ld_opbus_oe", operand_bus, 16'h004A);
        ir_oe = 1'b0; #1;

        // Hold: bus changes ignored
        ir_write = 1'b0; bus = 16'h1234;
        for (int i = 0; i < 5; i++) begin
            step();
            check("hold_ir_out", ir_out, 16'h004A);
        end
        check("hold_valid", {15'd0, ir_valid}, 16'd1);

        // Back-to-back loads
        ir_write = 1'b1; bus = 16'hA123;
        step();
        check("b2b1_ir_out", ir_out, 16'hA123);
        check("b2b1_opcode", {12'd0, opcode}, 16'h000A);
        bus = 16'h5FFF;
        step();
        check("b2b2_opcode",  {12'd0, opcode}, 16'h0005);
        check("b2b2_operand", {4'd0, operand}, 16'h0FFF);
        ir_oe = 1'b1; #1;
        check("b2b2_opbus_oe", operand_bus, 16'h0FFF);
        ir_oe = 1'b0; #1;
        check("b2b2_opbus_off", operand_bus, 16'h0000);

        // Strobe held across edges: last capture wins
        bus = 16'h1111;
        step();
        bus = 16'h2222;
        step();
        ir_write = 1'b0; bus = 16'h3333;
        step();
        check("multi_ir_out", ir_out, 16'h2222);

        // Reset beats load at the same edge
        rst = 1'b0; ir_write = 1'b1; bus = 16'hBEEF;
        step();
        check("prio_ir_out", ir_out, 16'h0000);
        check("prio_valid",  {15'd0, ir_valid}, 16'd0);
        rst = 1'b1; ir_write = 1'b0;
        step();
        check("post_rst_ir_out", ir_out, 16'h0000);
        check("post_rst_valid",  {15'd0, ir_valid}, 16'd0);

`ifdef IR_ILLEGAL_DET_EN
        legal_mask = 16'h00FF;
        ir_write = 1'b1; bus = 16'hF000;
        step();
        check("ill_set", {15'd0, ir_illegal}, 16'd1);
        bus = 16'h3000;
        step();
        check("ill_clr", {15'd0, ir_illegal}, 16'd0);
        ir_write = 1'b0; bus = 16'hF000;
        step();
        check("ill_hold", {15'd0, ir_illegal}, 16'd0);
        ir_write = 1'b1;
        step();
        check("ill_set2", {15'd0, ir_illegal}, 16'd1);
        rst = 1'b0;
        step();
        check("ill_rst", {15'd0, ir_illegal}, 16'd0);
        rst = 1'b1; ir_write = 1'b0;
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
